// File: rtl/shift_cmd_sequencer_if.sv
// Command and result handshake bundle for shift_cmd_sequencer.
// master drives commands and consumes results; slave is the sequencer.
interface shift_cmd_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_data;
  logic [3:0]       cmd_amt;
  logic             cmd_dir;
  logic             cmd_arith;
  logic [TAG_W-1:0] cmd_tag;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output cmd_valid, cmd_data, cmd_amt,
    output cmd_dir, cmd_arith, cmd_tag,
    output res_ready,
    input  cmd_ready, res_valid,
    input  res_data, res_tag
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amt,
    input  cmd_dir, cmd_arith, cmd_tag,
    input  res_ready,
    output cmd_ready, res_valid,
    output res_data, res_tag
  );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Command FIFO and pass sequencer feeding an 8-bit barrel shifter.
// Amounts 8..15 run as two passes so the shifter only sees 0..7.
module shift_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_cmd_sequencer_if.slave  bus,
  output logic [7:0]            sh_in,
  output logic [3:0]            sh_ctrl,
  output logic                  sh_dir,
  output logic                  sh_arith,
  input  logic [7:0]            sh_out,
  output logic                  busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0]       data;
    logic [3:0]       amt;
    logic             dir;
    logic             arith;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    DONE
  } state_e;

  state_e           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [3:0]       amt_q, amt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       sh_in_q, sh_in_d;
  logic [3:0]       sh_ctrl_q, sh_ctrl_d;
  logic             sh_dir_q, sh_dir_d;
  logic             sh_arith_q, sh_arith_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             busy_q, busy_d;
  logic             cmd_ready;
  logic             push;
  logic             pop;

  assign cmd_in.data  = bus.cmd_data;
  assign cmd_in.amt   = bus.cmd_amt;
  assign cmd_in.dir   = bus.cmd_dir;
  assign cmd_in.arith = bus.cmd_arith;
  assign cmd_in.tag   = bus.cmd_tag;

  // Ready and pop both look only at the registered count,
  // so a full FIFO never accepts and a fresh entry waits an edge.
  assign cmd_ready = (cnt_q != FULL);
  assign push      = bus.cmd_valid & cmd_ready;
  assign pop       = (state_q == IDLE) && (cnt_q != '0);
  assign head      = mem_q[rd_q];

  always_comb begin
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    amt_d       = amt_q;
    tag_d       = tag_q;
    sh_in_d     = sh_in_q;
    sh_ctrl_d   = sh_ctrl_q;
    sh_dir_d    = sh_dir_q;
    sh_arith_d  = sh_arith_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;

    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          sh_in_d    = head.data;
          sh_ctrl_d  = (head.amt > 4'd7) ? 4'd7 : head.amt;
          sh_dir_d   = head.dir;
          sh_arith_d = head.arith;
          amt_d      = head.amt;
          tag_d      = head.tag;
          state_d    = PASS1;
        end
      end
      PASS1: begin
        if (amt_q <= 4'd7) begin
          res_data_d  = sh_out;
          res_tag_d   = tag_q;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          // 15 would need 8 more; 7 gives the same all-fill result
          sh_in_d   = sh_out;
          sh_ctrl_d = (amt_q == 4'd15) ? 4'd7 : amt_q - 4'd7;
          state_d   = PASS2;
        end
      end
      PASS2: begin
        res_data_d  = sh_out;
        res_tag_d   = tag_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase

    busy_d = (state_d != IDLE) || (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      amt_q       <= '0;
      tag_q       <= '0;
      sh_in_q     <= '0;
      sh_ctrl_q   <= '0;
      sh_dir_q    <= 1'b0;
      sh_arith_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      amt_q       <= amt_d;
      tag_q       <= tag_d;
      sh_in_q     <= sh_in_d;
      sh_ctrl_q   <= sh_ctrl_d;
      sh_dir_q    <= sh_dir_d;
      sh_arith_q  <= sh_arith_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign sh_in         = sh_in_q;
  assign sh_ctrl       = sh_ctrl_q;
  assign sh_dir        = sh_dir_q;
  assign sh_arith      = sh_arith_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed and random bench for shift_cmd_sequencer.
// Includes a behavioural barrel shifter and an in-order scoreboard.
module tb_shift_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [7:0] d;
    logic [3:0] t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sh_in;
  logic [3:0] sh_ctrl;
  logic       sh_dir;
  logic       sh_arith;
  logic [7:0] sh_out;
  logic       busy;
  logic       rr_fix  = 1'b0;
  logic       rand_rr = 1'b0;
  logic       rnd_rr  = 1'b0;

  int errs    = 0;
  int checks  = 0;
  int acc_cnt = 0;
  int res_cnt = 0;
  exp_t q[$];

  shift_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

  shift_cmd_sequencer #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sh_in    (sh_in),
    .sh_ctrl  (sh_ctrl),
    .sh_dir   (sh_dir),
    .sh_arith (sh_arith),
    .sh_out   (sh_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Shifter stand-in: ctrl is always 0..7 here
  logic [15:0] ext;
  logic [15:0] lsh;
  always_comb begin
    ext    = {{8{sh_arith & sh_in[7]}}, sh_in} >> sh_ctrl;
    lsh    = {8'h00, sh_in} << sh_ctrl;
    sh_out = sh_dir ? ext[7:0] : lsh[7:0];
  end

  assign bus.res_ready = rand_rr ? rnd_rr : rr_fix;

  always @(posedge clk) rnd_rr <= 1'($urandom_range(0, 1));

  function automatic logic [7:0] ref_shift(
    input logic [7:0] d,
    input logic [3:0] a,
    input logic       dr,
    input logic       ar
  );
    logic [23:0] r;
    logic [15:0] l;
    r = {{16{ar & d[7]}}, d} >> a;
    l = {8'h00, d} << a;
    return dr ? r[7:0] : l[7:0];
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        res_cnt++;
        if (q.size() == 0) begin
          chk("res_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("res_data", 32'(bus.res_data), 32'(e.d));
          chk("res_tag", 32'(bus.res_tag), 32'(e.t));
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_t e;
        acc_cnt++;
        e.d = ref_shift(bus.cmd_data, bus.cmd_amt,
                        bus.cmd_dir, bus.cmd_arith);
        e.t = bus.cmd_tag;
        q.push_back(e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [7:0] d,
    input logic [3:0] a,
    input logic       dr,
    input logic       ar,
    input logic [3:0] t
  );
    int k;
    bus.cmd_data  = d;
    bus.cmd_amt   = a;
    bus.cmd_dir   = dr;
    bus.cmd_arith = ar;
    bus.cmd_tag   = t;
    bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin
      tick();
      k++;
    end
    if (!bus.cmd_ready) chk("push_timeout", 0, 1);
    else tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res;
    int k;
    k = 0;
    while (!bus.res_valid && k < 20) begin
      tick();
      k++;
    end
    if (!bus.res_valid) chk("res_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while ((busy || bus.res_valid) && k < lim) begin
      tick();
      k++;
    end
    if (busy || bus.res_valid) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int a0;
    int r0;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_amt   = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_arith = 1'b0;
    bus.cmd_tag   = '0;

    tick();
    tick();
    chk("rst_outs",
        32'({sh_in, sh_ctrl, sh_dir, sh_arith, bus.res_valid,
             bus.res_data, bus.res_tag, busy}), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    rr_fix = 1'b1;
    rst    = 1'b0;
    tick();

    push(8'hD1, 4'd2, 1'b0, 1'b0, 4'd1);
    chk("t1_n0_valid", 32'(bus.res_valid), 0);
    tick();
    chk("t1_ctrl", 32'(sh_ctrl), 2);
    chk("t1_in", 32'(sh_in), 32'h D1);
    chk("t1_n1_valid", 32'(bus.res_valid), 0);
    tick();
    chk("t1_valid", 32'(bus.res_valid), 1);
    chk("t1_data", 32'(bus.res_data), 32'h44);
    chk("t1_tag", 32'(bus.res_tag), 1);
    tick();

    push(8'hD1, 4'd4, 1'b1, 1'b1, 4'd2);
    wait_res();
    chk("t2_sra4", 32'(bus.res_data), 32'hFD);
    tick();
    push(8'hD1, 4'd1, 1'b1, 1'b0, 4'd3);
    wait_res();
    chk("t2_srl1", 32'(bus.res_data), 32'h68);
    tick();

    push(8'hD1, 4'd10, 1'b1, 1'b1, 4'd4);
    tick();
    chk("t3r_ctrl1", 32'(sh_ctrl), 7);
    tick();
    chk("t3r_ctrl2", 32'(sh_ctrl), 3);
    chk("t3r_n2_valid", 32'(bus.res_valid), 0);
    tick();
    chk("t3r_valid", 32'(bus.res_valid), 1);
    chk("t3r_data", 32'(bus.res_data), 32'hFF);
    tick();

    push(8'hD1, 4'd10, 1'b0, 1'b0, 4'd5);
    tick();
    chk("t3l_ctrl1", 32'(sh_ctrl), 7);
    tick();
    chk("t3l_ctrl2", 32'(sh_ctrl), 3);
    tick();
    chk("t3l_valid", 32'(bus.res_valid), 1);
    chk("t3l_data", 32'(bus.res_data), 32'h00);
    tick();

    wait_idle(50);
    rr_fix = 1'b0;
    tick();
    a0 = acc_cnt;
    r0 = res_cnt;
    n  = 0;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_data  = 8'h90 + 8'(n);
      bus.cmd_amt   = 4'(n * 3);
      bus.cmd_dir   = n[0];
      bus.cmd_arith = 1'b1;
      bus.cmd_tag   = 4'(n + 8);
      tick();
      n = acc_cnt - a0;
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepts", 32'(acc_cnt - a0), DEPTH + 1);
    chk("bp_ready", 32'(bus.cmd_ready), 0);
    chk("bp_hold", 32'(bus.res_valid), 1);
    chk("bp_nores", 32'(res_cnt - r0), 0);
    rr_fix = 1'b1;
    wait_idle(100);
    chk("bp_drained", 32'(res_cnt - r0), DEPTH + 1);
    chk("bp_q_empty", 32'(q.size()), 0);

    push(8'h5A, 4'd12, 1'b1, 1'b0, 4'd6);
    push(8'h11, 4'd1, 1'b0, 1'b0, 4'd7);
    push(8'h22, 4'd2, 1'b0, 1'b0, 4'd8);
    chk("r_pass2_ctrl", 32'(sh_ctrl), 5);
    chk("r_busy_pre", 32'(busy), 1);
    r0  = res_cnt;
    rst = 1'b1;
    tick();
    chk("r_valid", 32'(bus.res_valid), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_ready", 32'(bus.cmd_ready), 1);
    rst = 1'b0;
    repeat (12) tick();
    chk("r_no_stale", 32'(res_cnt - r0), 0);
    chk("r_idle", 32'(busy), 0);

    rand_rr = 1'b1;
    for (int i = 0; i < 48; i++) begin
      push(8'($urandom), 4'(i % 16),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'(i));
      if ($urandom_range(0, 3) == 0) tick();
    end
    wait_idle(1000);
    rand_rr = 1'b0;
    chk("rand_q_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Upstream command stage for the 8-bit barrel shifter `barrel_shift_8bit`.
- Accepts shift commands over a valid/ready handshake and queues them in a small FIFO.
- Drives the shifter's `in`/`ctrl`/`dir`/`arithmetic` inputs from registers and captures its combinational `out`.
- Returns tagged results over a valid/ready handshake. Shift amounts 8..15 are executed as two shifter passes (7, then amt-7), so every 4-bit amount is legal.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- TAG_W, 4, width of the pass-through command tag

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept (= !full, registered-count based)
- cmd_data  input  8  operand
- cmd_amt  input  4  shift amount 0..15
- cmd_dir  input  1  1 = right shift, 0 = left shift
- cmd_arith  input  1  1 = sign fill on right shift (ignored for left)
- cmd_tag  input  TAG_W  returned with result
- sh_in  output  8  to shifter `in`, registered
- sh_ctrl  output  4  to shifter `ctrl`, registered, always 0..7
- sh_dir  output  1  to shifter `dir`, registered
- sh_arith  output  1  to shifter `arithmetic`, registered
- sh_out  input  8  from shifter `out`, combinational
- res_valid  output  1  result held
- res_ready  input  1  consumer accepts
- res_data  output  8  shifted result
- res_tag  output  TAG_W  tag of result
- busy  output  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (synchronous, any cycle):
  - FIFO emptied; state IDLE.
  - All registered outputs 0: sh_*, res_valid, res_data, res_tag, busy.
  - cmd_ready = 1 in the first cycle after reset.
  - An in-flight command and all queued commands are discarded; no result is produced for them.
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - No bypass: an entry pushed at edge N is poppable no earlier than edge N+1.
  - When full, cmd_ready = 0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, PASS1, PASS2, DONE:
  - IDLE: if FIFO non-empty, pop at the edge and load sh_in=data, sh_ctrl=min(amt,7), sh_dir, sh_arith; latch amt and tag; go to PASS1.
  - PASS1: at the edge, if amt<=7, capture res_data=sh_out and go to DONE. Otherwise load sh_in=sh_out, sh_ctrl=amt-7 (1..8; amt=15 is issued as 7 then 8 is not allowed, so clamp pass2 ctrl to 7 — the result is identical, all fill), then go to PASS2.
  - PASS2: capture res_data=sh_out, go to DONE.
  - DONE: res_valid=1, res_data and res_tag stable. On res_valid & res_ready go to IDLE and drop res_valid at that edge.
- Latency:
  - Command pushed at edge N: res_valid rises after edge N+2 (amt<=7) or N+3 (amt>=8).
  - Back-to-back throughput: one result per 3 cycles (amt<=7) with res_ready held high.
- Width rules: sh_ctrl never exceeds 7, so the shifter's invalid-amount path is never exercised.
- res_ready back-pressure: the FSM stalls in DONE; the FIFO continues accepting until full.
- res_data ordering matches command acceptance order.

Test Plan:
- Reset, then push {data=0xD1, amt=2, dir=0, arith=0, tag=1}, res_ready=1 -> res_valid 2 cycles after push, res_data=0x44, res_tag=1, sh_ctrl=2.
- Push {0xD1, amt=4, dir=1, arith=1} -> res_data=0xFD; then {0xD1, amt=1, dir=1, arith=0} -> res_data=0x68.
- Push {0xD1, amt=10, dir=1, arith=1} -> sh_ctrl=7 in PASS1, then 3 in PASS2; res_data=0xFF at 3-cycle latency. Same with dir=0 -> 0x00.
- Hold res_ready=0 and push DEPTH+2 commands -> cmd_ready drops after DEPTH+1 accepts (DEPTH queued + 1 in DONE). Release res_ready -> all results return in order with correct tags.
- Assert rst while in PASS2 with 2 commands queued -> next cycle res_valid=0, busy=0, cmd_ready=1; no stale results emitted afterwards.
- Random commands over all amt 0..15 and both dir/arith values, with random res_ready -> every result matches the reference model (right arithmetic fills with data[7]; amt>=8 gives 0x00 or 0xFF).
